// File: rtl/pair_cnt_pkg.sv
// Shared constants and state type for the paired up/down counters.
// The up-counter reuses X_RST, Y_RST and CEIL_DEF from here.
package pair_cnt_pkg;

  localparam int WIDTH_DEF = 11;
  localparam int STEP_DEF  = 2;
  localparam int FLOOR_DEF = 2;
  localparam int CEIL_DEF  = 200;

  localparam int X_RST = 2;
  localparam int Y_RST = 1;

  // One-hot so that a corrupted state register is trivially detectable.
  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    DRAIN = 3'b010,
    DONE  = 3'b100
  } drain_state_t;

endpackage

// File: rtl/pair_drain_counter.sv
// Loads an (x, y) pair over valid/ready and drains both in lock-step to FLOOR.
// Optional macro PAIR_DRAIN_ASSERT_EN adds concurrent invariant assertions.
module pair_drain_counter
  import pair_cnt_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int STEP  = STEP_DEF,
  parameter int FLOOR = FLOOR_DEF,
  parameter int CEIL  = CEIL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_x,
  input  logic [WIDTH-1:0] load_y,
  input  logic             selector,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             inv_ok,
  output logic             err
);

  localparam logic [WIDTH-1:0] CEIL_W  = WIDTH'(CEIL);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(FLOOR + STEP);
  localparam logic [WIDTH-1:0] X_RST_W = WIDTH'(X_RST);
  localparam logic [WIDTH-1:0] Y_RST_W = WIDTH'(Y_RST);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

  drain_state_t     state, state_nx;
  logic [WIDTH-1:0] x_cl, y_ld, diff_ld, diff_cur;
  logic             accept, can_step, step;

  // A clamp on x moves y by the same amount so the pair difference survives.
  assign x_cl     = (load_x > CEIL_W) ? CEIL_W : load_x;
  assign y_ld     = load_y - (load_x - x_cl);
  assign diff_ld  = load_x - load_y;
  assign diff_cur = x - y;

  assign accept   = (state == IDLE) && load_valid;
  assign can_step = (x >= LIMIT_W);
  assign step     = (state == DRAIN) && !selector && can_step;
  assign inv_ok   = (diff_cur == ONE_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (load_valid) state_nx = DRAIN;
      DRAIN:   if (!selector && !can_step) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state == IDLE);
    busy       = (state == DRAIN);
    done       = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x   <= X_RST_W;
      y   <= Y_RST_W;
      err <= 1'b0;
    end else if (accept) begin
      x <= x_cl;
      y <= y_ld;
      if (diff_ld != ONE_W) err <= 1'b1;
    end else if (step) begin
      x <= x - STEP_W;
      y <= y - STEP_W;
    end
  end

`ifdef PAIR_DRAIN_ASSERT_EN
  a_no_4_0:   assert property (@(posedge clk) disable iff (!rst) (x != WIDTH'(4)) || (y != '0));
  a_inv:      assert property (@(posedge clk) disable iff (!rst) !err |-> inv_ok);
  a_floor:    assert property (@(posedge clk) disable iff (!rst) (busy && !err) |-> (x >= WIDTH'(FLOOR)));
  a_onehot:   assert property (@(posedge clk) disable iff (!rst) $onehot(state));
  a_done_src: assert property (@(posedge clk) disable iff (!rst) done |-> ($past(state) == DRAIN));
`else
  // Assertions compiled out; ports, logic and timing are unchanged.
`endif

endmodule

// File: tb/tb_pair_drain_counter.sv
// Randomized scoreboard bench: stimulus pushes expected completions, a monitor pops on done.
module tb_pair_drain_counter;
  import pair_cnt_pkg::*;

  localparam int W    = WIDTH_DEF;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0, rst = 1'b1, load_valid = 1'b0, selector = 1'b0;
  logic [W-1:0] load_x = '0, load_y = '0, x, y;
  logic         load_ready, busy, done, inv_ok, err;

  int tests = 0, fails = 0, cyc = 0;
  bit err_m = 1'b0;

  typedef struct {int cyc; int x; int y; bit err;} exp_t;
  exp_t sb[$];
  exp_t e;

  pair_drain_counter dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_x(load_x), .load_y(load_y), .selector(selector),
    .x(x), .y(y), .busy(busy), .done(done), .inv_ok(inv_ok), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL done_unexpected: got done=1 expected no completion (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("done_x", int'(x), e.x);
        check("done_y", int'(y), e.y);
        check("done_err", int'(err), int'(e.err));
      end
    end
  end

  // Model: clamp, count decrements from the rules, locate the (n+1)-th drain cycle.
  task automatic run_txn(input int lx, input int ly, input bit [31:0] pat,
                         input int plen, input int hold_x, input bit keep_valid);
    int xc, yl, nd, xf, yf, a, zeros, j;
    bit inv, s;
    j = 0;
    while (!load_ready && j < 40) begin @(posedge clk); #1; j++; end
    check("ready_wait", int'(load_ready), 1);
    load_valid = 1'b1; load_x = W'(lx); load_y = W'(ly); selector = 1'($urandom);
    xc    = (lx > CEIL_DEF) ? CEIL_DEF : lx;
    yl    = (ly - (lx - xc)) & MASK;
    inv   = (((lx - ly) & MASK) == 1);
    err_m = err_m | !inv;
    nd    = (xc < FLOOR_DEF + STEP_DEF) ? 0 : (xc - FLOOR_DEF - STEP_DEF) / STEP_DEF + 1;
    xf    = xc - STEP_DEF * nd;
    yf    = (yl - STEP_DEF * nd) & MASK;
    @(posedge clk); #1;
    a = cyc;
    check("accept_x", int'(x), xc);
    check("accept_y", int'(y), yl);
    check("accept_err", int'(err), int'(err_m));
    check("accept_busy", int'(busy), 1);
    if (keep_valid) begin load_x = W'($urandom); load_y = W'($urandom); end
    else load_valid = 1'b0;
    zeros = 0; j = 0;
    while (zeros < nd + 1) begin
      s = (j < plen) ? pat[j] : 1'b0;
      selector = s;
      if (!s) zeros++;
      if (zeros == nd + 1) sb.push_back('{a + j + 1, xf, yf, err_m});
      @(posedge clk); #1;
      j++;
      check("inv_ok", int'(inv_ok), int'(inv));
      check("ready_low", int'(load_ready), 0);
      if (s && hold_x >= 0) check("hold_x", int'(x), hold_x);
    end
    load_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", int'(load_ready), 1);
    check("idle_busy", int'(busy), 0);
    check("idle_x", int'(x), xf);
  endtask

  initial begin
    int lx, ly;
    #12;
    rst = 1'b0;
    #1;
    check("rst_x", int'(x), X_RST);
    check("rst_y", int'(y), Y_RST);
    check("rst_ready", int'(load_ready), 1);
    check("rst_err", int'(err), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_inv", int'(inv_ok), 1);
    @(negedge clk) rst = 1'b1;

    run_txn(200, 199, 32'h0, 0, -1, 1'b0);
    run_txn(10, 9, 32'h3E, 6, 8, 1'b1);
    run_txn(3, 2, 32'h0, 0, -1, 1'b0);
    run_txn(250, 249, 32'h5, 4, -1, 1'b0);
    run_txn(10, 10, 32'h0, 0, -1, 1'b1);
    run_txn(6, 5, 32'h2, 3, -1, 1'b0);
    check("err_sticky", int'(err), 1);

    // Reset in the middle of a drain, with load_valid still asserted.
    @(posedge clk); #1;
    load_valid = 1'b1; load_x = W'(200); load_y = W'(199); selector = 1'b0;
    @(posedge clk); #1;
    load_x = W'(77); load_y = W'(76);
    repeat (50) @(posedge clk);
    #1;
    check("mid_x", int'(x), 100);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_x", int'(x), X_RST);
    check("mid_rst_y", int'(y), Y_RST);
    check("mid_rst_ready", int'(load_ready), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_err", int'(err), 0);
    err_m = 1'b0;
    load_valid = 1'b0;
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      lx = $urandom_range(0, 300);
      ly = ($urandom_range(0, 3) != 0) ? ((lx - 1) & MASK) : $urandom_range(0, MASK);
      run_txn(lx, ly, $urandom, $urandom_range(0, 12), -1, 1'($urandom));
    end

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    tests++; fails++;
    $display("FAIL timeout: got no end of stimulus expected completion within bound");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
